// File: rtl/cae_pkg.sv
// Shared types and sizing helpers for the CAE row-convolution datapath.
package cae_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COMP  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic MODE_SLIDE = 1'b0;
  localparam logic MODE_BLOCK = 1'b1;

  // Number of stride-1 windows of width k that fit in a row.
  function automatic int unsigned num_windows(input int unsigned row_len, input int unsigned k);
    return row_len - k + 1;
  endfunction

  // Number of stride-k chunks covering a row; the last one may be partial.
  function automatic int unsigned num_chunks(input int unsigned row_len, input int unsigned k);
    return (row_len + k - 1) / k;
  endfunction

endpackage

// File: rtl/pe_dot_k.sv
// Combinational K-tap signed multiply-add, full-precision products.
module pe_dot_k #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned KERNEL     = 3,
  parameter int unsigned ACC_WIDTH  = 21
) (
  input  logic [KERNEL*DATA_WIDTH-1:0] data,
  input  logic [KERNEL*DATA_WIDTH-1:0] weight,
  output logic signed [ACC_WIDTH-1:0]  dot_c
);

  localparam int unsigned PROD_W = 2 * DATA_WIDTH;

  logic signed [PROD_W-1:0] prod_c [KERNEL];

  // Per-tap products, operands sign-extended before multiplying.
  always_comb begin
    for (int k = 0; k < int'(KERNEL); k++) begin
      prod_c[k] = PROD_W'($signed(data[k*DATA_WIDTH +: DATA_WIDTH])) *
                  PROD_W'($signed(weight[k*DATA_WIDTH +: DATA_WIDTH]));
    end
  end

  // Sign-extend each product to the accumulator width and sum.
  always_comb begin
    dot_c = '0;
    for (int k = 0; k < int'(KERNEL); k++) begin
      dot_c = dot_c + ACC_WIDTH'(prod_c[k]);
    end
  end

endmodule

// File: rtl/conv_row_pe.sv
// Row-convolution PE: sliding K-tap conv (mode 0) or blocked dot product (mode 1).
module conv_row_pe
  import cae_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ROW_LEN    = 28,
  parameter int unsigned KERNEL     = 3,
  parameter int unsigned ACC_WIDTH  = 2 * DATA_WIDTH + $clog2(ROW_LEN)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          mode,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [ROW_LEN*DATA_WIDTH-1:0] data_in,
  input  logic [ROW_LEN*DATA_WIDTH-1:0] weight_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [ACC_WIDTH-1:0]   out_data,
  output logic [$clog2(ROW_LEN)-1:0]    out_idx,
  output logic                          out_last,
  output logic                          busy
);

  localparam int unsigned IDX_W   = $clog2(ROW_LEN);
  localparam int unsigned NW      = num_windows(ROW_LEN, KERNEL);
  localparam int unsigned NCH     = num_chunks(ROW_LEN, KERNEL);
  localparam int unsigned ROW_W   = ROW_LEN * DATA_WIDTH;
  localparam int unsigned PAD_W   = NCH * KERNEL * DATA_WIDTH;
  localparam int unsigned WIN_W   = KERNEL * DATA_WIDTH;
  localparam int unsigned BASE_W  = $clog2(PAD_W);
  localparam logic [IDX_W-1:0] LAST_WIN   = IDX_W'(NW - 1);
  localparam logic [IDX_W-1:0] LAST_CHUNK = IDX_W'(NCH - 1);

  if (ROW_LEN < KERNEL || KERNEL == 0 || ROW_LEN < 2) begin : g_param_check
    $error("conv_row_pe: ROW_LEN must be >= KERNEL >= 1 and ROW_LEN >= 2");
  end

  state_t                       state;
  logic                         mode_q;
  logic [ROW_W-1:0]             data_q;
  logic [ROW_W-1:0]             weight_q;
  logic [IDX_W-1:0]             idx_q;
  logic signed [ACC_WIDTH-1:0]  acc_q;
  logic [PAD_W-1:0]             data_pad_c;
  logic [PAD_W-1:0]             weight_pad_c;
  logic [BASE_W-1:0]            base_c;
  logic [WIN_W-1:0]             win_data_c;
  logic [WIN_W-1:0]             win_weight_c;
  logic signed [ACC_WIDTH-1:0]  dot_c;
  logic                         capture_c;
  logic                         advance_c;

  assign capture_c = in_valid && in_ready;
  assign advance_c = !out_valid || out_ready;

  // Zero-extend the latched rows so the last blocked chunk reads zeros past ROW_LEN.
  always_comb begin
    data_pad_c               = '0;
    weight_pad_c             = '0;
    data_pad_c[ROW_W-1:0]    = data_q;
    weight_pad_c[ROW_W-1:0]  = weight_q;
  end

  // Window/chunk select: stride 1 over data with fixed taps, or stride K over both rows.
  always_comb begin
    base_c = (mode_q == MODE_SLIDE) ? BASE_W'(idx_q) * BASE_W'(DATA_WIDTH)
                                    : BASE_W'(idx_q) * BASE_W'(WIN_W);
    win_data_c   = data_pad_c[base_c +: WIN_W];
    win_weight_c = (mode_q == MODE_SLIDE) ? weight_pad_c[WIN_W-1:0]
                                          : weight_pad_c[base_c +: WIN_W];
  end

  pe_dot_k #(
    .DATA_WIDTH (DATA_WIDTH),
    .KERNEL     (KERNEL),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_dot (
    .data   (win_data_c),
    .weight (win_weight_c),
    .dot_c  (dot_c)
  );

  // Row capture; contents are meaningless until the first accepted job.
  always_ff @(posedge clk) begin
    if (capture_c) begin
      data_q   <= data_in;
      weight_q <= weight_in;
    end
  end

  // Job control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mode_q    <= MODE_SLIDE;
      idx_q     <= '0;
      acc_q     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (capture_c) begin
            mode_q   <= mode;
            idx_q    <= '0;
            acc_q    <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= COMP;
          end
        end
        COMP: begin
          if (mode_q == MODE_SLIDE) begin
            if (advance_c) begin
              out_valid <= 1'b1;
              out_data  <= dot_c;
              out_idx   <= idx_q;
              out_last  <= (idx_q == LAST_WIN);
              if (idx_q == LAST_WIN) begin
                state <= DRAIN;
              end else begin
                idx_q <= idx_q + IDX_W'(1);
              end
            end
          end else begin
            if (idx_q == LAST_CHUNK) begin
              out_valid <= 1'b1;
              out_data  <= acc_q + dot_c;
              out_idx   <= '0;
              out_last  <= 1'b1;
              state     <= DRAIN;
            end else begin
              acc_q <= acc_q + dot_c;
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        DRAIN: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_row_pe.sv
// Directed scoreboard bench for conv_row_pe (default instance and a K=5/ROW_LEN=12 instance).
module tb_conv_row_pe;

  localparam int DW   = 8;
  localparam int RL_A = 28;
  localparam int K_A  = 3;
  localparam int AW_A = 2 * DW + $clog2(RL_A);
  localparam int IW_A = $clog2(RL_A);
  localparam int RL_B = 12;
  localparam int K_B  = 5;
  localparam int AW_B = 2 * DW + $clog2(RL_B);
  localparam int IW_B = $clog2(RL_B);

  typedef struct {
    logic signed [31:0] data;
    int                 idx;
    bit                 last;
  } exp_t;

  logic clk, rst, mode, in_valid, out_ready, sel, corrupt;
  logic in_valid_a, in_valid_b;
  logic [RL_A*DW-1:0] data_a, weight_a;
  logic [RL_B*DW-1:0] data_b, weight_b;
  logic in_ready_a, out_valid_a, out_last_a, busy_a;
  logic in_ready_b, out_valid_b, out_last_b, busy_b;
  logic signed [AW_A-1:0] out_data_a;
  logic signed [AW_B-1:0] out_data_b;
  logic [IW_A-1:0] out_idx_a;
  logic [IW_B-1:0] out_idx_b;

  logic               obs_valid, obs_last, obs_busy, obs_in_ready;
  logic signed [31:0] obs_data;
  logic [31:0]        obs_idx;

  int   d_arr [RL_A];
  int   w_arr [RL_A];
  exp_t sb [$];
  int   checks;
  int   errors;

  assign in_valid_a = in_valid & ~sel;
  assign in_valid_b = in_valid & sel;

  conv_row_pe u_dut_a (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .data_in(data_a), .weight_in(weight_a), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_data(out_data_a), .out_idx(out_idx_a), .out_last(out_last_a), .busy(busy_a)
  );

  conv_row_pe #(.DATA_WIDTH(DW), .ROW_LEN(RL_B), .KERNEL(K_B)) u_dut_b (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .data_in(data_b), .weight_in(weight_b), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_data(out_data_b), .out_idx(out_idx_b), .out_last(out_last_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pack the element arrays onto the row buses; corrupt scrambles them after capture.
  always_comb begin
    data_a = '0; weight_a = '0; data_b = '0; weight_b = '0;
    for (int i = 0; i < RL_A; i++) begin
      data_a[i*DW +: DW]   = DW'(d_arr[i]) ^ {DW{corrupt}};
      weight_a[i*DW +: DW] = DW'(w_arr[i]) ^ {DW{corrupt}};
    end
    for (int i = 0; i < RL_B; i++) begin
      data_b[i*DW +: DW]   = DW'(d_arr[i]) ^ {DW{corrupt}};
      weight_b[i*DW +: DW] = DW'(w_arr[i]) ^ {DW{corrupt}};
    end
  end

  // Observe whichever instance is selected.
  always_comb begin
    obs_valid    = sel ? out_valid_b : out_valid_a;
    obs_last     = sel ? out_last_b  : out_last_a;
    obs_busy     = sel ? busy_b      : busy_a;
    obs_in_ready = sel ? in_ready_b  : in_ready_a;
    obs_data     = sel ? 32'($signed(out_data_b)) : 32'($signed(out_data_a));
    obs_idx      = sel ? 32'(out_idx_b) : 32'(out_idx_a);
  end

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push_model(input bit m, input int rl, input int k);
    exp_t e;
    int   s;
    if (m == 1'b0) begin
      for (int w = 0; w <= rl - k; w++) begin
        s = 0;
        for (int j = 0; j < k; j++) s += d_arr[w + j] * w_arr[j];
        e.data = s; e.idx = w; e.last = (w == rl - k);
        sb.push_back(e);
      end
    end else begin
      s = 0;
      for (int i = 0; i < rl; i++) s += d_arr[i] * w_arr[i];
      e.data = s; e.idx = 0; e.last = 1'b1;
      sb.push_back(e);
    end
  endtask

  task automatic run_job(input bit m, input int lat_exp, input bit bp, input int abort_idx);
    exp_t               e;
    bit                 seen, held, done;
    logic signed [31:0] h_data;
    logic [31:0]        h_idx;
    logic               h_last;
    push_model(m, sel ? RL_B : RL_A, sel ? K_B : K_A);
    @(negedge clk);
    corrupt = 1'b0; mode = m; in_valid = 1'b1; out_ready = 1'b1;
    chk("in_ready_idle", 32'(obs_in_ready), 1);
    @(negedge clk);
    mode = ~m; corrupt = 1'b1;
    chk("busy_after_capture", 32'(obs_busy), 1);
    chk("in_ready_busy", 32'(obs_in_ready), 0);
    seen = 0; held = 0; done = 0;
    for (int t = 0; t < 2000 && !done; t++) begin
      if (t > 0) @(negedge clk);
      if (obs_valid && !seen) begin
        seen = 1;
        if (lat_exp >= 0) chk("latency", t, lat_exp);
      end
      if (held) begin
        chk("stall_valid", 32'(obs_valid), 1);
        chk("stall_data", obs_data, h_data);
        chk("stall_idx", obs_idx, h_idx);
        chk("stall_last", 32'(obs_last), 32'(h_last));
      end
      held = 0;
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (obs_valid && out_ready) begin
        chk("sb_nonempty", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("data", obs_data, e.data);
          chk("idx", obs_idx, e.idx);
          chk("last", 32'(obs_last), 32'(e.last));
          if (e.last) done = 1;
          if (abort_idx >= 0 && e.idx == abort_idx) begin
            in_valid = 1'b0;
            #2 rst = 1'b1;
            #1;
            chk("abort_out_valid", 32'(obs_valid), 0);
            chk("abort_busy", 32'(obs_busy), 0);
            chk("abort_in_ready", 32'(obs_in_ready), 1);
            chk("abort_out_data", obs_data, 0);
            chk("abort_out_idx", obs_idx, 0);
            chk("abort_out_last", 32'(obs_last), 0);
            sb.delete();
            @(negedge clk);
            rst = 1'b0;
            corrupt = 1'b0;
            return;
          end
        end
      end else if (obs_valid) begin
        held = 1; h_data = obs_data; h_idx = obs_idx; h_last = obs_last;
      end
      if (done) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    chk("job_done", 32'(done), 1);
    @(negedge clk);
    chk("post_in_ready", 32'(obs_in_ready), 1);
    chk("post_busy", 32'(obs_busy), 0);
    chk("post_out_valid", 32'(obs_valid), 0);
    chk("sb_empty", 32'(sb.size()), 0);
    corrupt = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b1; in_valid = 1'b0; sel = 1'b0; mode = 1'b0; out_ready = 1'b0; corrupt = 1'b0;
    for (int i = 0; i < RL_A; i++) begin d_arr[i] = 0; w_arr[i] = 0; end
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready_a), 1);
    chk("rst_out_valid", 32'(out_valid_a), 0);
    chk("rst_out_data", 32'($signed(out_data_a)), 0);
    chk("rst_out_idx", 32'(out_idx_a), 0);
    chk("rst_out_last", 32'(out_last_a), 0);
    chk("rst_busy", 32'(busy_a), 0);
    rst = 1'b0;

    // Sliding conv, ramp data, unit taps
    for (int i = 0; i < RL_A; i++) begin d_arr[i] = i; w_arr[i] = 1; end
    run_job(1'b0, 1, 1'b0, -1);

    // Blocked dot, constant rows
    for (int i = 0; i < RL_A; i++) begin d_arr[i] = 2; w_arr[i] = -3; end
    run_job(1'b1, 10, 1'b0, -1);

    // Sliding conv under random backpressure
    for (int i = 0; i < RL_A; i++) begin d_arr[i] = i; w_arr[i] = 1; end
    run_job(1'b0, -1, 1'b1, -1);

    // Most-negative operands in both modes
    for (int i = 0; i < RL_A; i++) begin d_arr[i] = -128; w_arr[i] = -128; end
    run_job(1'b1, 10, 1'b0, -1);
    run_job(1'b0, 1, 1'b0, -1);

    // Random signed rows, both modes, with backpressure
    for (int i = 0; i < RL_A; i++) begin
      d_arr[i] = int'($urandom_range(0, 255)) - 128;
      w_arr[i] = int'($urandom_range(0, 255)) - 128;
    end
    run_job(1'b0, -1, 1'b1, -1);
    run_job(1'b1, -1, 1'b1, -1);

    // Async reset mid-job after window 10, then a clean job
    for (int i = 0; i < RL_A; i++) begin d_arr[i] = i; w_arr[i] = 1; end
    run_job(1'b0, 1, 1'b0, 10);
    run_job(1'b0, 1, 1'b0, -1);

    // K=5, ROW_LEN=12 instance
    sel = 1'b1;
    for (int i = 0; i < RL_A; i++) begin d_arr[i] = 1; w_arr[i] = 1; end
    run_job(1'b1, 3, 1'b0, -1);
    run_job(1'b0, 1, 1'b0, -1);
    for (int i = 0; i < RL_A; i++) begin
      d_arr[i] = int'($urandom_range(0, 255)) - 128;
      w_arr[i] = int'($urandom_range(0, 255)) - 128;
    end
    run_job(1'b1, 3, 1'b1, -1);
    run_job(1'b0, -1, 1'b1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
